// File: rtl/mips_pkg.sv
// Shared types, constants and target arithmetic for the MIPS fetch front end.
// Helpers work on a 64-bit address; callers truncate to their own ADDR_W.
package mips_pkg;

    localparam int INST_BYTES      = 4;
    localparam int JUMP_REGION_MSB = 28;
    localparam int WIDE_ADDR_W     = 64;

    typedef logic [WIDE_ADDR_W-1:0] wide_addr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Address of the instruction after pc; the byte offset bits of pc are ignored.
    function automatic wide_addr_t seq_pc(input wide_addr_t pc);
        return (pc & ~wide_addr_t'(3)) + wide_addr_t'(INST_BYTES);
    endfunction

    function automatic wide_addr_t branch_target(input wide_addr_t pc, input logic [15:0] imm);
        return seq_pc(pc) + {{(WIDE_ADDR_W-18){imm[15]}}, imm, 2'b00};
    endfunction

    function automatic wide_addr_t jump_target(input wide_addr_t pc, input logic [25:0] index);
        return (seq_pc(pc) & ~((wide_addr_t'(1) << JUMP_REGION_MSB) - wide_addr_t'(1)))
             | wide_addr_t'({index, 2'b00});
    endfunction

endpackage

// File: rtl/mips_fetch_queue.sv
// In-order prefetch FIFO with flush; push and pop may coincide at any occupancy.
// Pointers carry one extra MSB so full and empty are distinguishable.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited memory requests,
// queues responses in order, and handles branch/jump redirects and sticky halt.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              br_taken,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [15:0]       res_imm,
    input  logic [25:0]       res_index,
    input  logic              halt_in,
    output logic              halted
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard_cnt;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic              redirect_req;
    logic              redirect;
    logic              credit_ok;
    logic              grant;
    logic              push;
    logic              pop;
    logic              flush;
    entry_t            push_entry;
    entry_t            head;

    assign redirect_req = jump_en | br_taken;
    assign redirect     = redirect_req & ~halt_in & ~halted;
    assign target       = jump_en ? ADDR_W'(jump_target(wide_addr_t'(res_pc), res_index))
                                  : ADDR_W'(branch_target(wide_addr_t'(res_pc), res_imm));

    // In-flight requests plus queued entries never exceed the queue depth.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, q_count}) < (CNT_W+1)'(QUEUE_DEPTH);
    assign imem_req   = rst_b & ~halted & ~halt_in & ~redirect_req & credit_ok;
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req & imem_gnt;

    assign push       = imem_rvalid & (discard_cnt == '0) & ~redirect & ~halt_in & ~halted;
    assign inst_valid = rst_b & ~q_empty & ~redirect_req & ~halt_in;
    assign pop        = inst_valid & inst_ready;
    assign flush      = redirect | halt_in;
    assign push_entry = '{pc: rsp_pc, inst: imem_rdata};
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    mips_fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
            // Halt and redirect both orphan everything still in flight; a response
            // landing this very cycle is dropped directly, so it is not counted.
            if (halt_in) begin
                halted      <= 1'b1;
                discard_cnt <= outstanding - CNT_W'(imem_rvalid);
            end else if (redirect) begin
                fetch_pc    <= target;
                rsp_pc      <= target;
                discard_cnt <= outstanding - CNT_W'(imem_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
                if (imem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - CNT_W'(1);
                if (push) rsp_pc <= rsp_pc + ADDR_W'(INST_BYTES);
            end
        end
    end

    no_queue_overflow: assert property (@(posedge clk) disable iff (!rst_b)
        !(push && q_full && !pop));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus random traffic, checked against
// a request/queue-level model with an in-order memory of random latency.
module tb_mips_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        br_taken;
    logic        jump_en;
    logic [31:0] res_pc;
    logic [15:0] res_imm;
    logic [25:0] res_index;
    logic        halt_in;
    logic        halted;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .RESET_PC    (32'h0),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .br_taken    (br_taken),
        .jump_en     (jump_en),
        .res_pc      (res_pc),
        .res_imm     (res_imm),
        .res_index   (res_index),
        .halt_in     (halt_in),
        .halted      (halted)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } req_t;

    req_t        pend[$];     // requests granted but not yet answered by memory
    logic [31:0] exp_q[$];    // PCs decode should see next, in order
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch;
    bit          m_halted;
    int          cyc = 0;
    int          n_grants = 0;
    int          n_pops = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_target(input bit jmp, input logic [31:0] rpc,
                                                 input logic [15:0] imm, input logic [25:0] idx);
        logic [31:0] p4;
        int          off;
        p4 = (rpc & 32'hFFFF_FFFC) + 32'd4;
        if (jmp) return (p4 & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        off = $signed(imm);
        return p4 + 32'(off * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: drive at negedge, compare just after, advance the model at posedge.
    task automatic cycle(input bit rst, input bit gnt, input bit rdy, input bit br, input bit jmp,
                         input logic [31:0] rpc, input logic [15:0] imm, input logic [25:0] idx,
                         input bit hlt);
        bit          rv;
        bit          gr;
        bit          pp;
        bit          redir;
        logic [31:0] ga;
        int          due;
        req_t        r;
        @(negedge clk);
        rst_b = rst; imem_gnt = gnt; inst_ready = rdy; br_taken = br; jump_en = jmp;
        res_pc = rpc; res_imm = imm; res_index = idx; halt_in = hlt;
        rv = rst && pend.size() > 0 && pend[0].due <= cyc;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend[0].addr) : 32'h0;
        #1;
        check("imem_req", {31'd0, imem_req},
              {31'd0, rst && !m_halted && !hlt && !(br || jmp) && (pend.size() + exp_q.size() < DEPTH)});
        check("inst_valid", {31'd0, inst_valid}, {31'd0, rst && exp_q.size() > 0 && !(br || jmp) && !hlt});
        if (rst) begin
            check("imem_addr", imem_addr, m_fetch);
            check("halted", {31'd0, halted}, {31'd0, m_halted});
            if (inst_valid && exp_q.size() > 0) begin
                check("inst_pc", inst_pc, exp_q[0]);
                check("inst", inst, mem_word(exp_q[0]));
            end
        end
        gr    = imem_req && gnt;
        ga    = imem_addr;
        pp    = inst_valid && rdy;
        redir = rst && (br || jmp) && !hlt && !m_halted;
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            exp_q.delete();
            m_fetch  = 32'h0;
            m_halted = 1'b0;
        end else begin
            if (pp && exp_q.size() > 0) begin
                pop_log.push_back(exp_q.pop_front());
                n_pops++;
            end
            if (rv) begin
                r = pend.pop_front();
                if (r.live && !redir && !hlt && !m_halted) exp_q.push_back(r.addr);
            end
            if (gr) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (pend.size() > 0 && pend[$].due > due) due = pend[$].due;
                pend.push_back('{addr: ga, due: due, live: 1'b1});
                n_grants++;
            end
            if (hlt) begin
                m_halted = 1'b1;
                exp_q.delete();
                foreach (pend[i]) pend[i].live = 1'b0;
            end else if (redir) begin
                exp_q.delete();
                foreach (pend[i]) pend[i].live = 1'b0;
                m_fetch = model_target(jmp, rpc, imm, idx);
            end else if (gr) begin
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit gnt, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, gnt, rdy, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
    endtask

    initial begin
        rst_b = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; br_taken = 1'b0; jump_en = 1'b0; res_pc = 32'h0;
        res_imm = 16'h0; res_index = 26'h0; halt_in = 1'b0;
        m_fetch = 32'h0; m_halted = 1'b0;

        // Reset, then streaming with 1-cycle memory: one instruction per cycle from cycle 2.
        do_reset();
        do_reset();
        n_pops = 0;
        pop_log.delete();
        run(12, 1'b1, 1'b1);
        check("stream_pops", n_pops, 10);
        check("stream_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h0);
        check("stream_last_pc", pop_log.size() > 9 ? pop_log[9] : 32'hFFFF_FFFF, 32'd36);

        // Decode stalled: credit limit allows exactly DEPTH requests, then drains in order.
        do_reset();
        n_grants = 0;
        run(8, 1'b1, 1'b0);
        check("stall_grants", n_grants, DEPTH);
        pop_log.delete();
        run(4, 1'b0, 1'b1);
        check("drain_count", pop_log.size(), 4);
        check("drain_pc0", pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h0);
        check("drain_pc3", pop_log.size() > 3 ? pop_log[3] : 32'hFFFF_FFFF, 32'hC);

        // Backward branch with three requests in flight on a 3-cycle memory.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        n_grants = 0;
        run(3, 1'b1, 1'b1);
        check("br_inflight", n_grants, 3);
        pop_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 16'hFFFC, 26'h0, 1'b0);
        #1 check("br_fetch_pc", imem_addr, 32'h4);
        run(10, 1'b1, 1'b1);
        check("br_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hFFFF_FFFF, 32'h4);

        // Jump wins over a simultaneous branch.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hF000_0008, 16'h1234, 26'h100, 1'b0);
        #1 check("jump_priority", imem_addr, 32'hF000_0400);
        run(6, 1'b1, 1'b1);

        // Fetch PC wraps past the top of the address space.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hF000_0000, 16'h0, 26'h3FF_FFFF, 1'b0);
        #1 check("wrap_start", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
        #1 check("wrap_next", imem_addr, 32'h0);
        run(8, 1'b1, 1'b1);

        // Halt with two requests in flight; later redirect must be ignored.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        run(2, 1'b1, 1'b1);
        pop_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b1);
        #1 check("halt_set", {31'd0, halted}, 32'd1);
        run(4, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 16'h10, 26'h0, 1'b0);
        #1 check("halt_ignores_redirect", imem_addr, 32'h8);
        run(3, 1'b1, 1'b1);
        check("halt_no_delivery", pop_log.size(), 0);
        do_reset();
        #1 check("rst_clears_halt", {31'd0, halted}, 32'd0);

        // Reset in the middle of streaming traffic.
        lat_lo = 1; lat_hi = 3;
        run(10, 1'b1, 1'b1);
        do_reset();
        #1 check("rst_addr", imem_addr, 32'h0);
        run(6, 1'b1, 1'b1);

        // Random traffic: grants, backpressure, redirects, rare halts and resets.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 800; i++) begin
            bit          r_rst;
            bit          r_br;
            bit          r_jmp;
            bit          r_hlt;
            r_rst = ($urandom_range(99) != 0);
            r_br  = ($urandom_range(15) == 0);
            r_jmp = ($urandom_range(24) == 0);
            r_hlt = ($urandom_range(149) == 0);
            cycle(r_rst, $urandom_range(3) != 0, $urandom_range(9) < 7, r_br, r_jmp,
                  $urandom, 16'($urandom), 26'($urandom), r_hlt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
